// File: rtl/multi_channel_timed_latch.sv
// Multi-channel timed latch: each channel stretches a trigger into an output held
// for a programmable number of cycles, with retrigger or lockout behaviour per channel.
module multi_channel_timed_latch #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned COUNT_WIDTH   = 32,
    parameter int unsigned DEFAULT_DELAY = 25000000,
    parameter int unsigned EDGE_TRIGGER  = 0,
    localparam int unsigned CHAN_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    trigger,
    input  logic                   cfg_we,
    input  logic [CHAN_W-1:0]      cfg_chan,
    input  logic [COUNT_WIDTH-1:0] cfg_delay,
    input  logic                   cfg_retrig,
    output logic [CHANNELS-1:0]    out,
    output logic [CHANNELS-1:0]    expired,
    output logic                   busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] DEF_DELAY = COUNT_WIDTH'(DEFAULT_DELAY);
    localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

    state_t                 state_q [CHANNELS];
    state_t                 state_d [CHANNELS];
    logic [COUNT_WIDTH-1:0] count_q [CHANNELS];
    logic [COUNT_WIDTH-1:0] count_d [CHANNELS];
    logic [COUNT_WIDTH-1:0] delay_q [CHANNELS];
    logic [COUNT_WIDTH-1:0] delay_d [CHANNELS];

    logic [CHANNELS-1:0] mode_q, mode_d;       // configured mode, 1 = retrigger
    logic [CHANNELS-1:0] run_rt_q, run_rt_d;   // mode captured at load
    logic [CHANNELS-1:0] lock_q, lock_d;
    logic [CHANNELS-1:0] trig_q;
    logic [CHANNELS-1:0] ev;
    logic [CHANNELS-1:0] out_d, expired_d;

    assign ev = (EDGE_TRIGGER != 0) ? (trigger & ~trig_q) : trigger;

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            count_d[i]   = count_q[i];
            delay_d[i]   = delay_q[i];
            mode_d[i]    = mode_q[i];
            run_rt_d[i]  = run_rt_q[i];
            lock_d[i]    = lock_q[i];
            expired_d[i] = 1'b0;

            if (!trigger[i]) begin
                lock_d[i] = 1'b0;
            end

            case (state_q[i])
                IDLE: begin
                    if (ev[i] && !lock_q[i]) begin
                        state_d[i]  = ACTIVE;
                        count_d[i]  = delay_q[i];
                        run_rt_d[i] = mode_q[i];
                    end
                end
                ACTIVE: begin
                    // A retrigger reload takes priority over expiry in the same cycle.
                    if (ev[i] && run_rt_q[i]) begin
                        count_d[i] = delay_q[i];
                    end else if (count_q[i] != '0) begin
                        count_d[i] = count_q[i] - ONE;
                    end else begin
                        state_d[i]   = IDLE;
                        expired_d[i] = 1'b1;
                        if (!run_rt_q[i] && trigger[i]) begin
                            lock_d[i] = 1'b1;
                        end
                    end
                end
                default: state_d[i] = IDLE;
            endcase

            // Config lands after the load decision above, so a same-cycle load uses old values.
            if (cfg_we && (32'(cfg_chan) == i)) begin
                delay_d[i] = cfg_delay;
                mode_d[i]  = cfg_retrig;
            end

            out_d[i] = (state_d[i] == ACTIVE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                count_q[i] <= '0;
                delay_q[i] <= DEF_DELAY;
            end
            mode_q   <= '1;
            run_rt_q <= '1;
            lock_q   <= '0;
            trig_q   <= '0;
            out      <= '0;
            expired  <= '0;
            busy     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
                delay_q[i] <= delay_d[i];
            end
            mode_q   <= mode_d;
            run_rt_q <= run_rt_d;
            lock_q   <= lock_d;
            trig_q   <= trigger;
            out      <= out_d;
            expired  <= expired_d;
            busy     <= |out_d;
        end
    end

endmodule
